// File: rtl/bf_bracket_scanner.sv
// Loop-jump resolver: walks program memory from a bracket to its matching partner.
// Optional BF_SCAN_STATS_EN adds a scan_len output counting bytes fetched per scan.
module bf_bracket_scanner #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] prog_last,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] target_pc
`ifdef BF_SCAN_STATS_EN
  ,
  output logic [ADDR_W-1:0] scan_len
`endif
);

  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;

  typedef enum logic [1:0] {IDLE, FETCH, FIN} state_t;

  state_t              state;
  logic                dir_q;
  logic [DEPTH_W-1:0]  depth;
  logic [ADDR_W-1:0]   pc;

  logic                hit_same;
  logic                hit_opp;
  logic                at_bound;
  logic                start_bound;
  logic                depth_full;
  logic [ADDR_W-1:0]   pc_next;
  logic [ADDR_W-1:0]   start_next;

  // Byte classification relative to the origin bracket, plus bound checks.
  always_comb begin
    hit_same    = dir_q ? (mem_data == CH_CLOSE) : (mem_data == CH_OPEN);
    hit_opp     = dir_q ? (mem_data == CH_OPEN)  : (mem_data == CH_CLOSE);
    at_bound    = dir_q ? (pc == '0) : (pc == prog_last);
    pc_next     = dir_q ? (pc - ADDR_W'(1)) : (pc + ADDR_W'(1));
    start_bound = dir ? (start_pc == '0) : (start_pc == prog_last);
    start_next  = dir ? (start_pc - ADDR_W'(1)) : (start_pc + ADDR_W'(1));
    depth_full  = &depth;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      depth     <= '0;
      pc        <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      target_pc <= '0;
`ifdef BF_SCAN_STATS_EN
      scan_len  <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dir_q <= dir;
            depth <= '0;
            busy  <= 1'b1;
`ifdef BF_SCAN_STATS_EN
            scan_len <= '0;
`endif
            // Origin already at the edge of the program: nothing to scan.
            if (start_bound) begin
              state <= FIN;
              err   <= 1'b1;
            end else begin
              state    <= FETCH;
              pc       <= start_next;
              mem_req  <= 1'b1;
              mem_addr <= start_next;
            end
          end
        end
        FETCH: begin
          if (mem_ack) begin
`ifdef BF_SCAN_STATS_EN
            scan_len <= scan_len + ADDR_W'(1);
`endif
            if (hit_opp && depth == '0) begin
              target_pc <= pc;
              done      <= 1'b1;
              mem_req   <= 1'b0;
              state     <= FIN;
            end else if ((hit_same && depth_full) || at_bound) begin
              err     <= 1'b1;
              mem_req <= 1'b0;
              state   <= FIN;
            end else begin
              if (hit_same) begin
                depth <= depth + DEPTH_W'(1);
              end else if (hit_opp) begin
                depth <= depth - DEPTH_W'(1);
              end
              pc       <= pc_next;
              mem_addr <= pc_next;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_bracket_scanner.sv
// Directed bench for bf_bracket_scanner: a small program ROM, tied or randomly delayed acks.
// Built with DEPTH_W=2 so the depth-overflow error is reachable with a short program.
module tb_bf_bracket_scanner;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DEPTH_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              dir = 1'b0;
  logic [ADDR_W-1:0] start_pc = '0;
  logic [ADDR_W-1:0] prog_last = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b1;
  logic [7:0]        mem_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] target_pc;
`ifdef BF_SCAN_STATS_EN
  logic [ADDR_W-1:0] scan_len;
`endif

  logic [7:0] prog [16];

  int total = 0;
  int bad   = 0;

  int   r_cyc;
  int   r_fetch;
  int   r_addr_bad;
  logic r_done;
  logic r_err;
  logic r_req;

  bf_bracket_scanner #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .start_pc  (start_pc),
    .prog_last (prog_last),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .target_pc (target_pc)
`ifdef BF_SCAN_STATS_EN
    ,
    .scan_len  (scan_len)
`endif
  );

  always #5 clk = ~clk;

  assign mem_data = prog[mem_addr[3:0]];

  task automatic load_prog(input string s);
    for (int i = 0; i < 16; i++) begin
      prog[i] = (i < s.len()) ? s[i] : 8'h20;
    end
    prog_last = ADDR_W'(s.len() - 1);
  endtask

  // Runs one scan; stimulus and sampling happen on the falling edge.
  task automatic run_scan(input logic d, input logic [ADDR_W-1:0] spc, input bit rnd,
                          input int mid_start);
    int                wait_cnt;
    logic              waiting;
    logic [ADDR_W-1:0] held;
    r_cyc = 0; r_fetch = 0; r_addr_bad = 0;
    r_done = 1'b0; r_err = 1'b0; r_req = 1'b0;
    wait_cnt = 0; waiting = 1'b0; held = '0;
    @(negedge clk);
    start = 1'b1; dir = d; start_pc = spc;
    mem_ack = rnd ? 1'b0 : 1'b1;
    while (r_cyc < 200 && !r_done && !r_err) begin
      @(negedge clk);
      start = 1'b0;
      r_cyc++;
      if (r_cyc == mid_start) begin
        start = 1'b1; dir = ~d; start_pc = '0;
      end
      r_done = done;
      r_err  = err;
      if (mem_req) r_req = 1'b1;
      if (waiting && (mem_req !== 1'b1 || mem_addr !== held)) r_addr_bad++;
      if (rnd) begin
        if (mem_req && wait_cnt == 0) begin
          mem_ack  = 1'b1;
          wait_cnt = $urandom_range(0, 5);
        end else begin
          mem_ack = 1'b0;
          if (wait_cnt > 0) wait_cnt--;
        end
      end
      waiting = mem_req && !mem_ack;
      held    = mem_addr;
      if (mem_req && mem_ack) r_fetch++;
    end
    start = 1'b0;
    total++;
    if (r_cyc >= 200) begin
      bad++; $display("FAIL scan_timeout cycles=%0d limit=200", r_cyc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL rst_done_err got=%b%b want=00", done, err);
    end
    total++; if (mem_req !== 1'b0 || mem_addr !== '0) begin
      bad++; $display("FAIL rst_mem got req=%b addr=%0d want 0/0", mem_req, mem_addr);
    end
    total++; if (target_pc !== '0) begin
      bad++; $display("FAIL rst_target got=%0d want=0", target_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_forward_outer();
    load_prog("[+[-]>]");
    run_scan(1'b0, 16'd0, 1'b0, 0);
    total++; if (r_done !== 1'b1 || r_cyc !== 7) begin
      bad++; $display("FAIL fwd0_done done=%b cyc=%0d want done=1 cyc=7", r_done, r_cyc);
    end
    total++; if (target_pc !== 16'd6) begin
      bad++; $display("FAIL fwd0_target got=%0d want=6", target_pc);
    end
    total++; if (r_fetch !== 6) begin
      bad++; $display("FAIL fwd0_fetches got=%0d want=6", r_fetch);
    end
`ifdef BF_SCAN_STATS_EN
    total++; if (scan_len !== 16'd6) begin
      bad++; $display("FAIL fwd0_scan_len got=%0d want=6", scan_len);
    end
`endif
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL fwd0_after got busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_backward_and_inner();
    load_prog("[+[-]>]");
    run_scan(1'b1, 16'd6, 1'b0, 0);
    total++; if (r_done !== 1'b1 || target_pc !== 16'd0 || r_fetch !== 6) begin
      bad++; $display("FAIL bwd6 done=%b target=%0d fetch=%0d want 1/0/6", r_done, target_pc, r_fetch);
    end
    run_scan(1'b1, 16'd4, 1'b0, 0);
    total++; if (r_done !== 1'b1 || target_pc !== 16'd2 || r_cyc !== 3) begin
      bad++; $display("FAIL bwd4 done=%b target=%0d cyc=%0d want 1/2/3", r_done, target_pc, r_cyc);
    end
    run_scan(1'b0, 16'd2, 1'b0, 0);
    total++; if (r_done !== 1'b1 || target_pc !== 16'd4 || r_fetch !== 2) begin
      bad++; $display("FAIL fwd2 done=%b target=%0d fetch=%0d want 1/4/2", r_done, target_pc, r_fetch);
    end
  endtask

  task automatic test_unmatched();
    load_prog("[[+]");
    run_scan(1'b0, 16'd0, 1'b0, 0);
    total++; if (r_err !== 1'b1 || r_done !== 1'b0 || r_cyc !== 4) begin
      bad++; $display("FAIL unmatched err=%b done=%b cyc=%0d want 1/0/4", r_err, r_done, r_cyc);
    end
    total++; if (target_pc !== 16'd4 || r_fetch !== 3) begin
      bad++; $display("FAIL unmatched_keep target=%0d fetch=%0d want 4/3", target_pc, r_fetch);
    end
    total++; if (busy !== 1'b1) begin
      bad++; $display("FAIL unmatched_fin_busy got=%b want=1", busy);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL unmatched_after busy=%b err=%b want 0/0", busy, err);
    end
  endtask

  task automatic test_edge_start();
    load_prog("[[+]");
    run_scan(1'b1, 16'd0, 1'b0, 0);
    total++; if (r_err !== 1'b1 || r_cyc !== 1 || r_req !== 1'b0) begin
      bad++; $display("FAIL bwd_at0 err=%b cyc=%0d req=%b want 1/1/0", r_err, r_cyc, r_req);
    end
    run_scan(1'b0, 16'd3, 1'b0, 0);
    total++; if (r_err !== 1'b1 || r_cyc !== 1 || r_req !== 1'b0) begin
      bad++; $display("FAIL fwd_at_last err=%b cyc=%0d req=%b want 1/1/0", r_err, r_cyc, r_req);
    end
  endtask

  task automatic test_depth_overflow();
    load_prog("[[[[[[");
    run_scan(1'b0, 16'd0, 1'b0, 0);
    total++; if (r_err !== 1'b1 || r_fetch !== 4 || r_cyc !== 5) begin
      bad++; $display("FAIL depth_ovf err=%b fetch=%0d cyc=%0d want 1/4/5", r_err, r_fetch, r_cyc);
    end
  endtask

  task automatic test_random_ack();
    load_prog("[+[-]>]");
    run_scan(1'b0, 16'd0, 1'b1, 3);
    mem_ack = 1'b1;
    total++; if (r_done !== 1'b1 || target_pc !== 16'd6 || r_fetch !== 6) begin
      bad++; $display("FAIL rnd_ack done=%b target=%0d fetch=%0d want 1/6/6", r_done, target_pc, r_fetch);
    end
    total++; if (r_addr_bad !== 0) begin
      bad++; $display("FAIL rnd_addr_stable got=%0d want=0", r_addr_bad);
    end
  endtask

  task automatic test_async_reset();
    logic pulse;
    load_prog("[+[-]>]");
    mem_ack = 1'b1;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; start_pc = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_req !== 1'b1) begin
      bad++; $display("FAIL arst_pre busy=%b req=%b want 1/1", busy, mem_req);
    end
    #1 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== '0 || target_pc !== '0) begin
      bad++; $display("FAIL arst_now busy=%b req=%b addr=%0d target=%0d want 0/0/0/0",
                      busy, mem_req, mem_addr, target_pc);
    end
    pulse = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || err) pulse = 1'b1;
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done || err || busy) pulse = 1'b1;
    end
    total++; if (pulse !== 1'b0) begin
      bad++; $display("FAIL arst_pulse got=%b want=0", pulse);
    end
    run_scan(1'b0, 16'd0, 1'b0, 0);
    total++; if (r_done !== 1'b1 || target_pc !== 16'd6 || r_cyc !== 7) begin
      bad++; $display("FAIL arst_rescan done=%b target=%0d cyc=%0d want 1/6/7", r_done, target_pc, r_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_forward_outer();
    test_backward_and_inner();
    test_unmatched();
    test_edge_start();
    test_depth_overflow();
    test_random_ack();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_bracket_scanner.md
# bf_bracket_scanner

Loop-jump resolver for the bfX core. When the executing instruction is a taken `[` (cell zero) or a taken `]` (cell non-zero), the control unit hands the current PC to this block. The block walks program memory forward or backward, counting bracket nesting with a depth counter, and returns the address of the matching bracket. It sits between the control FSM and the instruction-memory read port, and it owns that port only while busy.

## Interface
Parameters:
- ADDR_W, 16, program-address width
- DEPTH_W, 8, nesting-depth counter width

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only when idle
- dir  in  1  0 = forward (origin `[`, seek `]`); 1 = backward (origin `]`, seek `[`)
- start_pc  in  ADDR_W  address of the origin bracket
- prog_last  in  ADDR_W  last valid program address; stable while busy
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  read address
- mem_ack  in  1  read complete; mem_data valid in this cycle
- mem_data  in  8  ASCII instruction byte
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse: match found
- err  out  1  one-cycle pulse: no match (bound reached or depth overflow)
- target_pc  out  ADDR_W  matching-bracket address; held until next start

## Operation
- States: IDLE, FETCH, FIN.
- IDLE + start:
  - latch dir; depth <= 0; pc <= start_pc+1 (forward) or start_pc-1 (backward); go to FETCH.
  - If start_pc == prog_last (forward) or start_pc == 0 (backward): go to FIN with err instead.
- FETCH: mem_req=1, mem_addr=pc. On mem_ack, classify mem_data:
  - same char as origin (`[` forward, `]` backward): if depth is all-ones, go to FIN with err; else depth+1.
  - opposite char: if depth == 0, target_pc <= pc, go to FIN with done; else depth-1.
  - any other byte: ignored.
- Advance after a non-terminating ack:
  - forward: if pc == prog_last, err; else pc+1.
  - backward: if pc == 0, err; else pc-1.
  - pc never wraps.
- FIN: pulse done or err for one cycle, then go to IDLE.
- Arithmetic: pc and depth updates are plain unsigned ±1 in ADDR_W and DEPTH_W bits, with the bound checks above applied first.
- start while busy is ignored. dir and start_pc are sampled only on the accepted start.
- On err, target_pc keeps its previous value.

## Timing
- Reset: state IDLE. busy, done, err, mem_req = 0. mem_addr, target_pc, depth, pc = 0.
- busy is high from the cycle after the accepted start through the FIN cycle, inclusive.
- mem_req and mem_addr are registered and stay stable until the cycle in which mem_ack is high.
- mem_ack is ignored when mem_req is low.
- With mem_ack tied high, one byte is consumed per cycle. Latency from start to the done pulse is N+1 cycles for N bytes fetched.
- done or err asserts in the cycle after the terminating ack. target_pc is valid in that same cycle.
- Asynchronous reset mid-scan immediately forces the reset values above. No done or err pulse is produced.
- A start presented in the FIN cycle is ignored; the earliest new start is accepted in the following cycle.

## Configuration
- BF_SCAN_STATS_EN:
  - Defined: adds output scan_len [ADDR_W]. It is cleared on accepted start, incremented on each ack, and held from the done/err cycle until the next start. Reset value is 0.
  - Undefined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Program `[+[-]>]` at 0..6, prog_last=6, mem_ack tied 1, forward from 0 -> done, target_pc=6, 6 fetches (scan_len=6), done 7 cycles after start.
- Same program, backward from 6 -> target_pc=0. Backward from 4 -> target_pc=2. Forward from 2 -> target_pc=4.
- `[[+]`, prog_last=3, forward from 0 -> err after fetching address 3; target_pc unchanged; busy drops after the err cycle.
- Backward from start_pc=0, and forward from start_pc=prog_last -> err 1 cycle after start, no mem_req.
- Random 0-5 cycle mem_ack delays on `[+[-]>]` forward from 0 -> mem_addr stable while waiting, target_pc=6. A start pulsed mid-scan is ignored.
- rst asserted asynchronously mid-scan -> busy, mem_req, done, err drop immediately with no pulse. A new forward start from 0 then completes normally with target_pc=6.
